// File: rtl/ram_bist_ctrl.sv
// March-style write/read/compare BIST controller for a synchronous single-port-timing RAM.
// Define BIST_INV_PASS_EN to add a second pass that repeats the test with inverted patterns.
module ram_bist_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic              wr_enb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] data_in,
  output logic              rd_enb,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] data_out
);

  typedef enum logic [2:0] {IDLE, WR, RD, CMP, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] expected;
  logic [DATA_W-1:0] next_pattern;

  // Each word holds its own address and its complement, so shorts between
  // address lines or data bits show up as a mismatch somewhere in the sweep.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] p;
    p = '0;
    p[ADDR_W-1:0] = a;
    p[2*ADDR_W-1:ADDR_W] = ~a;
    return p;
  endfunction

  assign next_addr = addr + 1'b1;

`ifdef BIST_INV_PASS_EN
  logic inv_phase;
  assign expected     = inv_phase ? ~pattern(addr) : pattern(addr);
  assign next_pattern = inv_phase ? ~pattern(next_addr) : pattern(next_addr);
`else
  assign expected     = pattern(addr);
  assign next_pattern = pattern(next_addr);
`endif

  // All RAM strobes are registered: the values for a state are loaded on the
  // edge that enters it, so the RAM sees clean, glitch-free controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
      wr_enb    <= 1'b0;
      wr_addr   <= '0;
      data_in   <= '0;
      rd_enb    <= 1'b0;
      rd_addr   <= '0;
`ifdef BIST_INV_PASS_EN
      inv_phase <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= WR;
            addr      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
            wr_enb    <= 1'b1;
            wr_addr   <= '0;
            data_in   <= pattern('0);
`ifdef BIST_INV_PASS_EN
            inv_phase <= 1'b0;
`endif
          end
        end
        WR: begin
          if (addr == LAST_ADDR) begin
            state   <= RD;
            addr    <= '0;
            wr_enb  <= 1'b0;
            rd_enb  <= 1'b1;
            rd_addr <= '0;
          end else begin
            addr    <= next_addr;
            wr_addr <= next_addr;
            data_in <= next_pattern;
          end
        end
        RD: begin
          state  <= CMP;
          rd_enb <= 1'b0;
        end
        CMP: begin
          if (data_out != expected) begin
            state     <= DONE;
            fail_addr <= addr;
            fail_data <= data_out;
            pass      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else if (addr != LAST_ADDR) begin
            state   <= RD;
            addr    <= next_addr;
            rd_enb  <= 1'b1;
            rd_addr <= next_addr;
`ifdef BIST_INV_PASS_EN
          end else if (!inv_phase) begin
            state     <= WR;
            addr      <= '0;
            inv_phase <= 1'b1;
            wr_enb    <= 1'b1;
            wr_addr   <= '0;
            data_in   <= ~pattern('0);
`endif
          end else begin
            state <= DONE;
            pass  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: a faultable RAM model plus an abstract
// model of which word fails first and on which edge the run ends.
module tb_ram_bist_ctrl;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
`ifdef BIST_INV_PASS_EN
  localparam int PHASES = 2;
`else
  localparam int PHASES = 1;
`endif

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ADDR_W-1:0] fail_addr;
  logic [DATA_W-1:0] fail_data;
  logic              wr_enb;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic              rd_enb;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] data_out;

  ram_bist_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data),
    .wr_enb(wr_enb), .wr_addr(wr_addr), .data_in(data_in),
    .rd_enb(rd_enb), .rd_addr(rd_addr), .data_out(data_out)
  );

  typedef struct {
    int                start_cyc;
    int                latency;
    bit                pass;
    logic [ADDR_W-1:0] fa;
    logic [DATA_W-1:0] fd;
  } result_t;

  result_t sb[$];
  result_t mon_item;
  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int overlap = 0;
  logic prev_done = 1'b0;

  // fault_kind: 0 none, 1 stuck-at bit, 2 read returns all ones
  int   fault_kind = 0;
  int   fault_a = 0;
  int   fault_bit = 0;
  bit   fault_val = 0;
  bit   fault_inv_only = 0;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] ram_q = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [DATA_W-1:0] pat(input int a);
    return DATA_W'((((2**ADDR_W - 1) - a) << ADDR_W) | a);
  endfunction

  function automatic logic [DATA_W-1:0] corrupt(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    if (fault_kind == 1) r[fault_bit] = fault_val;
    else if (fault_kind == 2) r = '1;
    return r;
  endfunction

  // RAM: one-cycle read latency; the second-phase-only fault is recognised by the stored complement pattern
  always @(posedge clk) begin
    if (wr_enb) mem[wr_addr] <= data_in;
    if (rd_enb) begin
      if (fault_kind != 0 && int'(rd_addr) == fault_a &&
          (!fault_inv_only || mem[rd_addr] == ~pat(int'(rd_addr))))
        ram_q <= corrupt(mem[rd_addr]);
      else
        ram_q <= mem[rd_addr];
    end
  end
  assign data_out = ram_q;

  // Reference: sweep phases and words in order; the first word whose read differs decides the outcome
  function automatic result_t model(input int start_cyc);
    result_t r;
    logic [DATA_W-1:0] stored, rd;
    r.start_cyc = start_cyc;
    r.latency = PHASES * 3 * DEPTH;
    r.pass = 1'b1;
    r.fa = '0;
    r.fd = '0;
    for (int p = 0; p < PHASES; p++) begin
      for (int a = 0; a < DEPTH; a++) begin
        stored = (p == 1) ? ~pat(a) : pat(a);
        rd = stored;
        if (fault_kind != 0 && a == fault_a && (!fault_inv_only || p == 1)) rd = corrupt(stored);
        if (rd != stored) begin
          r.latency = p * 3 * DEPTH + DEPTH + 2 * (a + 1);
          r.pass = 1'b0;
          r.fa = ADDR_W'(a);
          r.fd = rd;
          return r;
        end
      end
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
  endtask

  // Monitor: on every rising done, pop the oldest expected run and compare
  always @(negedge clk) begin
    if (wr_enb && rd_enb) overlap++;
    if (rst_n && done && !prev_done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 1, 0);
      end else begin
        mon_item = sb.pop_front();
        checkOutput("latency", cyc - mon_item.start_cyc, mon_item.latency);
        checkOutput("pass", pass, mon_item.pass);
        checkOutput("fail_addr", fail_addr, mon_item.fa);
        checkOutput("fail_data", fail_data, mon_item.fd);
        checkOutput("busy_at_done", busy, 0);
      end
    end
    prev_done = done;
  end

  task automatic applyStimulus(input int kind, input int fa, input int fb, input bit fv,
                               input bit inv_only, input int busy_pulse_at, input int abort_at);
    fault_kind = kind;
    fault_a = fa;
    fault_bit = fb;
    fault_val = fv;
    fault_inv_only = inv_only;
    @(negedge clk);
    if (abort_at == 0) sb.push_back(model(cyc + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (busy_pulse_at > 0) begin
      repeat (busy_pulse_at - 2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    if (abort_at > 0) begin
      repeat (abort_at - 1) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkOutput("reset_midrun_outputs",
                     {busy, done, pass, fail_addr, fail_data, wr_enb, rd_enb, wr_addr, rd_addr, data_in}, 0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
      checkOutput("run_completed", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    #3 rst_n = 1'b0;
    #1 checkOutput("reset_outputs",
                   {busy, done, pass, fail_addr, fail_data, wr_enb, rd_enb, wr_addr, rd_addr, data_in}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("idle_after_reset", {busy, done, wr_enb, rd_enb}, 0);

    $display("[TB] clean run");
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    $display("[TB] stuck-at-0 bit0 at address 5");
    applyStimulus(1, 5, 0, 0, 0, 0, 0);
    $display("[TB] reset during write phase, then clean restart");
    applyStimulus(0, 0, 0, 0, 0, 0, 7);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    $display("[TB] start pulse while busy");
    applyStimulus(0, 0, 0, 0, 0, 20, 0);
    $display("[TB] address 15 corrupted only in complement phase");
    applyStimulus(2, 15, 0, 0, 1, 0, 0);

    $display("[TB] randomized faults");
    for (int n = 0; n < 10; n++) begin
      applyStimulus(int'($urandom_range(0, 2)), int'($urandom_range(0, DEPTH - 1)),
                    int'($urandom_range(0, DATA_W - 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 0, 0);
    end

    checkOutput("wr_rd_overlap", overlap, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
RAM_BIST_CTRL -- requirements
Module: ram_bist_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 4, meaning RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning RAM data width; DATA_W SHALL be at least 2*ADDR_W.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning words tested, addresses 0..DEPTH-1, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port start, input, 1 bit, meaning begin a test run when sampled high while not busy.
REQ-007 The block SHALL have port busy, output, 1 bit, meaning a test run is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, meaning the run has finished and results are valid.
REQ-009 The block SHALL have port pass, output, 1 bit, meaning all compares matched; valid only while done=1.
REQ-010 The block SHALL have port fail_addr, output, ADDR_W bits, meaning the address of the first mismatch.
REQ-011 The block SHALL have port fail_data, output, DATA_W bits, meaning the data read at the first mismatch.
REQ-012 The block SHALL have ports wr_enb (output, 1 bit), wr_addr (output, ADDR_W bits) and data_in (output, DATA_W bits), meaning RAM write strobe, write address and write data.
REQ-013 The block SHALL have ports rd_enb (output, 1 bit), rd_addr (output, ADDR_W bits) and data_out (input, DATA_W bits), meaning RAM read strobe, read address and read data.

Function
REQ-014 RAM read timing SHALL be: rd_enb/rd_addr sampled at an edge; data_out valid for the whole following cycle. A write takes effect at the edge sampling wr_enb=1.
REQ-015 The FSM SHALL have states IDLE, WR, RD, CMP, DONE.
REQ-016 Pattern SHALL be P(a) = {zero-pad, ~a[ADDR_W-1:0], a[ADDR_W-1:0]} (ADDR_W=4: P(0)=8'hF0, P(5)=8'hA5, P(15)=8'h0F).
REQ-017 In IDLE or DONE, start=1 at an edge SHALL clear pass, fail_addr, fail_data and done, set busy, and enter WR with address 0.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 WR SHALL drive wr_enb=1, wr_addr=a and data_in=P(a) for one cycle per address, a = 0..DEPTH-1 consecutively; after a=DEPTH-1 the FSM SHALL enter RD with a=0.
REQ-020 RD SHALL drive rd_enb=1 and rd_addr=a for one cycle, then enter CMP.
REQ-021 CMP SHALL compare data_out with P(a) at the edge ending the cycle; on match with a<DEPTH-1 the FSM SHALL enter RD with a+1; on match with a=DEPTH-1 it SHALL enter DONE with pass=1.
REQ-022 On the first mismatch the FSM SHALL latch fail_addr=a and fail_data=data_out, set pass=0, and enter DONE immediately.
REQ-023 wr_enb and rd_enb SHALL never be high in the same cycle, and both SHALL be 0 in IDLE and DONE.
REQ-024 busy SHALL be 1 exactly in WR, RD and CMP; done SHALL be 1 exactly in DONE, held until the next accepted start.
REQ-025 A clean run SHALL take DEPTH + 2*DEPTH edges from the start-sampling edge to the edge asserting done (48 for DEPTH=16).
REQ-026 Address counters SHALL not wrap past DEPTH-1.

Reset
REQ-027 rst_n=0 SHALL asynchronously force IDLE and set busy, done, pass, fail_addr, fail_data, wr_enb, rd_enb, wr_addr, rd_addr and data_in to 0, including mid-run.
REQ-028 After rst_n deasserts, the block SHALL stay in IDLE until start is sampled high.

Configuration
REQ-029 With macro BIST_INV_PASS_EN defined, after a clean first read phase the block SHALL repeat WR/RD/CMP using ~P(a), and reach DONE with pass=1 only if both phases match (clean run 96 edges for DEPTH=16); mismatches in the second phase SHALL be reported as in REQ-022.
REQ-030 Without BIST_INV_PASS_EN, only the P(a) phase SHALL run and no second-phase logic SHALL be present.

Verification
REQ-031 Clean run, DEPTH=16 with a fault-free RAM model: pulse start -> busy for 48 cycles, then done=1, pass=1, fail_addr=0, fail_data=0.
REQ-032 Stuck-at fault, RAM model returning bit 0 forced to 0 at address 5: run -> done=1, pass=0, fail_addr=5, fail_data=8'hA4, done at edge 28 after start.
REQ-033 Reset mid-WR: assert rst_n=0 at cycle 7 -> all outputs 0 immediately; a restart after release gives a clean run identical to REQ-031.
REQ-034 Start during busy: pulse start at cycle 20 -> ignored; run completes at cycle 48, and the trace shows wr_enb/rd_enb never both high.
REQ-035 With BIST_INV_PASS_EN and a RAM model corrupting only address 15 in the second phase (returns 8'hFF): run -> pass=0, fail_addr=15, fail_data=8'hFF; a clean RAM gives done at edge 96 with pass=1.
